// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM encoding, bus-level constants and the
// command-register opcodes shared with the master controller.
package i2c_pkg;

   typedef logic [2:0] target_state_t;

   localparam target_state_t StIdle    = 3'd0;
   localparam target_state_t StDevAddr = 3'd1;
   localparam target_state_t StAddrAck = 3'd2;
   localparam target_state_t StRegPtr  = 3'd3;
   localparam target_state_t StWrData  = 3'd4;
   localparam target_state_t StRdData  = 3'd5;
   localparam target_state_t StRdAck   = 3'd6;
   localparam target_state_t StIgnore  = 3'd7;

   localparam logic ACK      = 1'b0;
   localparam logic NACK     = 1'b1;
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   // Master command-register opcodes: START+WRITE, WRITE, STOP+WRITE.
   localparam logic [7:0] CMD_STA_WR = 8'h90;
   localparam logic [7:0] CMD_WR     = 8'h10;
   localparam logic [7:0] CMD_STO_WR = 8'h50;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronises one I2C line, rejects pulses shorter than FILTER_LEN clk samples
// and produces single-cycle rise/fall pulses aligned with the filtered level.
module i2c_line_filter #(
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic          sync1_q, sync2_q, filt_q, rise_q, fall_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         filt_q  <= 1'b1;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= line;
         sync2_q <= sync1_q;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         // Level flips only after FILTER_LEN consecutive samples disagree with it.
         if (sync2_q == filt_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_q <= sync2_q;
            rise_q <= sync2_q;
            fall_q <= ~sync2_q;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign level = filt_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file: device-address match, auto-incrementing
// register pointer, bus writes with fabric strobes, and register reads back to the master.
module i2c_target_regfile
   import i2c_pkg::*;
#(
   parameter logic [6:0]  DEVICE_ADDR = 7'h21,
   parameter int unsigned NUM_REGS    = 16,
   parameter int unsigned FILTER_LEN  = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        scl,
   inout  wire                         sda,
   output logic                        wr_strobe,
   output logic [7:0]                  wr_addr,
   output logic [7:0]                  wr_data,
   input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
   output logic [7:0]                  rd_val,
   output logic                        busy
);

   localparam int unsigned PW = $clog2(NUM_REGS);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .line  (scl),
      .level (scl_lvl),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .line  (sda),
      .level (sda_lvl),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   logic start_cond, stop_cond;
   assign start_cond = sda_fall & scl_lvl;
   assign stop_cond  = sda_rise & scl_lvl;

   target_state_t state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic          rw_q, rw_d;
   logic          ack_q, ack_d;       // byte received, ACK slot pending or in progress
   logic          ack_oe_q, ack_oe_d; // target is holding SDA low for an ACK
   logic          sda_oe_q, sda_oe_d;
   logic          busy_q, busy_d;
   logic          wr_strobe_d;
   logic [7:0]    wr_addr_d, wr_data_d;
   logic [7:0]    regs_q [NUM_REGS];
   logic [7:0]    byte_in;

   assign byte_in = {shift_q[6:0], sda_lvl};

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      ptr_d       = ptr_q;
      rw_d        = rw_q;
      ack_d       = ack_q;
      ack_oe_d    = ack_oe_q;
      busy_d      = busy_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr;
      wr_data_d   = wr_data;
      if (start_cond) begin
         state_d   = StDevAddr;
         bit_cnt_d = '0;
         ack_d     = 1'b0;
         ack_oe_d  = 1'b0;
         busy_d    = 1'b1;
      end else if (stop_cond) begin
         state_d   = StIdle;
         bit_cnt_d = '0;
         ack_d     = 1'b0;
         ack_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else begin
         case (state_q)
            StDevAddr: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     rw_d = byte_in[0];
                     // Address 0 (general call) is never acknowledged.
                     if (byte_in[7:1] == DEVICE_ADDR && byte_in[7:1] != 7'd0) begin
                        state_d = StAddrAck;
                     end else begin
                        state_d = StIgnore;
                     end
                  end
               end
            end
            StAddrAck: begin
               if (scl_fall) begin
                  if (!ack_oe_q) begin
                     ack_oe_d = 1'b1;
                  end else begin
                     ack_oe_d  = 1'b0;
                     bit_cnt_d = '0;
                     if (rw_q == RW_READ) begin
                        shift_d = regs_q[ptr_q];
                        state_d = StRdData;
                     end else begin
                        state_d = StRegPtr;
                     end
                  end
               end
            end
            StRegPtr, StWrData: begin
               if (scl_rise && !ack_q) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     ack_d = 1'b1;
                     if (state_q == StRegPtr) begin
                        ptr_d = byte_in[PW-1:0];
                     end else begin
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = 8'(ptr_q);
                        wr_data_d   = byte_in;
                        ptr_d       = ptr_q + 1'b1;
                     end
                  end
               end else if (scl_fall && ack_q) begin
                  if (!ack_oe_q) begin
                     ack_oe_d = 1'b1;
                  end else begin
                     ack_oe_d = 1'b0;
                     ack_d    = 1'b0;
                     state_d  = StWrData;
                  end
               end
            end
            StRdData: begin
               if (scl_fall) begin
                  shift_d   = {shift_q[6:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = StRdAck;
                  end
               end
            end
            StRdAck: begin
               if (scl_rise && !ack_q) begin
                  if (sda_lvl == ACK) begin
                     ptr_d = ptr_q + 1'b1;
                     ack_d = 1'b1;
                  end else begin
                     state_d = StIgnore;
                  end
               end else if (scl_fall && ack_q) begin
                  ack_d     = 1'b0;
                  bit_cnt_d = '0;
                  shift_d   = regs_q[ptr_q];
                  state_d   = StRdData;
               end
            end
            default: ;
         endcase
      end
      // Registered so the open-drain enable never glitches on decode.
      sda_oe_d = ack_oe_d | ((state_d == StRdData) & ~shift_d[7]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         ptr_q     <= '0;
         rw_q      <= RW_WRITE;
         ack_q     <= 1'b0;
         ack_oe_q  <= 1'b0;
         sda_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         ptr_q     <= ptr_d;
         rw_q      <= rw_d;
         ack_q     <= ack_d;
         ack_oe_q  <= ack_oe_d;
         sda_oe_q  <= sda_oe_d;
         busy_q    <= busy_d;
         wr_strobe <= wr_strobe_d;
         wr_addr   <= wr_addr_d;
         wr_data   <= wr_data_d;
         if (wr_strobe_d) regs_q[ptr_q] <= wr_data_d;
      end
   end

   assign sda    = sda_oe_q ? 1'b0 : 1'bz;
   assign rd_val = regs_q[rd_idx];
   assign busy   = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: a bit-banged I2C master drives SCL/SDA
// and each task checks ACKs, read data, strobes and register contents.
module tb_i2c_target_regfile;

   localparam int unsigned Q = 10; // clk cycles per quarter SCL period

   logic       clk = 1'b0;
   logic       rst_n;
   logic       scl;
   logic       sda_pull;
   wire        sda;
   logic       wr_strobe;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] rd_idx;
   logic [7:0] rd_val;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int strobe_cnt = 0;
   int stray_low = 0;
   logic [7:0] last_addr = 8'h00;
   logic [7:0] last_data = 8'h00;

   pullup (sda);
   assign sda = sda_pull ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_target_regfile #(
      .DEVICE_ADDR (7'h21),
      .NUM_REGS    (16),
      .FILTER_LEN  (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl       (scl),
      .sda       (sda),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_idx    (rd_idx),
      .rd_val    (rd_val),
      .busy      (busy)
   );

   always @(negedge clk) begin
      if (wr_strobe === 1'b1) begin
         strobe_cnt <= strobe_cnt + 1;
         last_addr  <= wr_addr;
         last_data  <= wr_data;
      end
      if (!sda_pull && sda === 1'b0) stray_low <= stray_low + 1;
   end

   task automatic wait_q(input int n = 1);
      repeat (n * Q) @(posedge clk);
      #1;
   endtask

   task automatic bus_start();
      sda_pull = 1'b0;
      wait_q();
      scl = 1'b1;
      wait_q();
      sda_pull = 1'b1;
      wait_q();
      scl = 1'b0;
      wait_q();
   endtask

   task automatic bus_stop();
      sda_pull = 1'b1;
      wait_q();
      scl = 1'b1;
      wait_q();
      sda_pull = 1'b0;
      wait_q(2);
   endtask

   task automatic send_bit(input logic b);
      sda_pull = ~b;
      wait_q();
      scl = 1'b1;
      wait_q(2);
      scl = 1'b0;
      wait_q();
   endtask

   task automatic recv_bit(output logic b);
      sda_pull = 1'b0;
      wait_q();
      scl = 1'b1;
      wait_q();
      b = sda;
      wait_q();
      scl = 1'b0;
      wait_q();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic mack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d[i] = b;
      end
      send_bit(mack);
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      scl      = 1'b1;
      sda_pull = 1'b0;
      rd_idx   = 4'd0;
      repeat (4) @(posedge clk);
      #1;
      checks += 5;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (wr_strobe !== 1'b0) begin
         errors++; $display("FAIL reset_strobe: got %b expected 0", wr_strobe);
      end
      if (wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr: got %h expected 00", wr_addr); end
      if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
      if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda_released: got %b expected 1", sda); end
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         #1;
         checks++;
         if (rd_val !== 8'h00) begin
            errors++; $display("FAIL reset_reg[%0d]: got %h expected 00", i, rd_val);
         end
      end
      rst_n = 1'b1;
      wait_q(2);
   endtask

   task automatic test_single_write();
      logic ack;
      int   base = strobe_cnt;
      bus_start();
      write_byte(8'h42, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL sw_dev_ack: got %b expected 0", ack); end
      write_byte(8'h03, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL sw_ptr_ack: got %b expected 0", ack); end
      write_byte(8'hA5, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL sw_data_ack: got %b expected 0", ack); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sw_busy_mid: got %b expected 1", busy); end
      bus_stop();
      checks += 4;
      if (busy !== 1'b0) begin errors++; $display("FAIL sw_busy_after_stop: got %b expected 0", busy); end
      if (strobe_cnt - base != 1) begin
         errors++; $display("FAIL sw_strobe_count: got %0d expected 1", strobe_cnt - base);
      end
      if (last_addr !== 8'h03) begin errors++; $display("FAIL sw_wr_addr: got %h expected 03", last_addr); end
      if (last_data !== 8'hA5) begin errors++; $display("FAIL sw_wr_data: got %h expected a5", last_data); end
      rd_idx = 4'd3;
      #1;
      checks++; if (rd_val !== 8'hA5) begin errors++; $display("FAIL sw_reg3: got %h expected a5", rd_val); end
   endtask

   task automatic test_wrap_write();
      logic ack;
      int   base = strobe_cnt;
      bus_start();
      write_byte(8'h42, ack);
      write_byte(8'h0F, ack);
      write_byte(8'h11, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wrap_ack1: got %b expected 0", ack); end
      write_byte(8'h22, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wrap_ack2: got %b expected 0", ack); end
      bus_stop();
      checks += 3;
      if (strobe_cnt - base != 2) begin
         errors++; $display("FAIL wrap_strobe_count: got %0d expected 2", strobe_cnt - base);
      end
      if (last_addr !== 8'h00) begin errors++; $display("FAIL wrap_last_addr: got %h expected 00", last_addr); end
      if (last_data !== 8'h22) begin errors++; $display("FAIL wrap_last_data: got %h expected 22", last_data); end
      rd_idx = 4'd15;
      #1;
      checks++; if (rd_val !== 8'h11) begin errors++; $display("FAIL wrap_reg15: got %h expected 11", rd_val); end
      rd_idx = 4'd0;
      #1;
      checks++; if (rd_val !== 8'h22) begin errors++; $display("FAIL wrap_reg0: got %h expected 22", rd_val); end
   endtask

   task automatic test_read();
      logic       ack;
      logic [7:0] d;
      bus_start();
      write_byte(8'h42, ack);
      write_byte(8'h02, ack);
      write_byte(8'h5C, ack);
      bus_stop();
      bus_start();
      write_byte(8'h42, ack);
      write_byte(8'h02, ack);
      bus_start(); // repeated START
      write_byte(8'h43, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_dev_ack: got %b expected 0", ack); end
      read_byte(d, 1'b0);
      checks++; if (d !== 8'h5C) begin errors++; $display("FAIL rd_byte0: got %h expected 5c", d); end
      read_byte(d, 1'b1);
      checks++; if (d !== 8'hA5) begin errors++; $display("FAIL rd_byte1: got %h expected a5", d); end
      wait_q();
      checks += 2;
      if (sda !== 1'b1) begin errors++; $display("FAIL rd_released_after_nack: got %b expected 1", sda); end
      if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy_before_stop: got %b expected 1", busy); end
      bus_stop();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_after_stop: got %b expected 0", busy); end
      // NACK left the pointer at 3, so a fresh read resumes there.
      bus_start();
      write_byte(8'h43, ack);
      read_byte(d, 1'b1);
      checks++; if (d !== 8'hA5) begin errors++; $display("FAIL rd_ptr_persist: got %h expected a5", d); end
      bus_stop();
   endtask

   task automatic test_wrong_addr();
      logic ack;
      logic [7:0] bytes [3] = '{8'h03, 8'hFF, 8'h00};
      int   sbase = strobe_cnt;
      int   lbase = stray_low;
      bus_start();
      write_byte(8'h84, ack);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wa_dev_nack: got %b expected 1", ack); end
      for (int i = 0; i < 3; i++) begin
         write_byte(bytes[i], ack);
         checks++;
         if (ack !== 1'b1) begin errors++; $display("FAIL wa_byte%0d_nack: got %b expected 1", i, ack); end
      end
      bus_stop();
      checks += 3;
      if (strobe_cnt != sbase) begin
         errors++; $display("FAIL wa_no_strobe: got %0d expected 0", strobe_cnt - sbase);
      end
      if (stray_low != lbase) begin
         errors++; $display("FAIL wa_sda_never_driven: got %0d expected 0", stray_low - lbase);
      end
      if (busy !== 1'b0) begin errors++; $display("FAIL wa_busy: got %b expected 0", busy); end
      bus_start();
      write_byte(8'h42, ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wa_recover_ack: got %b expected 0", ack); end
      write_byte(8'h04, ack);
      write_byte(8'h77, ack);
      bus_stop();
      rd_idx = 4'd4;
      #1;
      checks++; if (rd_val !== 8'h77) begin errors++; $display("FAIL wa_recover_reg4: got %h expected 77", rd_val); end
   endtask

   task automatic test_glitch();
      for (int w = 1; w <= 2; w++) begin
         @(posedge clk);
         #1 sda_pull = 1'b1;
         repeat (w) @(posedge clk);
         #1 sda_pull = 1'b0;
         wait_q(2);
         checks++;
         if (busy !== 1'b0) begin errors++; $display("FAIL glitch_%0dclk_busy: got %b expected 0", w, busy); end
      end
      bus_start();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_real_start: got %b expected 1", busy); end
      bus_stop();
   endtask

   task automatic test_abort_and_reset();
      logic ack;
      int   base = strobe_cnt;
      bus_start();
      write_byte(8'h42, ack);
      write_byte(8'h06, ack);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      bus_stop();
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      if (strobe_cnt != base) begin
         errors++; $display("FAIL abort_no_strobe: got %0d expected 0", strobe_cnt - base);
      end
      rd_idx = 4'd6;
      #1;
      checks++; if (rd_val !== 8'h00) begin errors++; $display("FAIL abort_reg6: got %h expected 00", rd_val); end
      // Pointer is 6 and regs[6] is 0, so the target drives its first data bit low.
      bus_start();
      write_byte(8'h43, ack);
      checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rst_rd_driving: got %b expected 0", sda); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rst_sda_released: got %b expected 1", sda); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      for (int i = 0; i < 3; i++) begin
         logic [3:0] idx_tab [3] = '{4'd3, 4'd4, 4'd15};
         rd_idx = idx_tab[i];
         #1;
         checks++;
         if (rd_val !== 8'h00) begin
            errors++; $display("FAIL rst_reg[%0d]: got %h expected 00", idx_tab[i], rd_val);
         end
      end
      scl = 1'b1;
      wait_q();
      rst_n = 1'b1;
      wait_q(2);
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_wrap_write();
      test_read();
      test_wrong_addr();
      test_glitch();
      test_abort_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- I2C target (responder) for the far end of the bus our I2C master controller drives.
- Decodes START/STOP, matches a 7-bit device address, ACKs bytes and writes a local register file with auto-increment.
- Serves register reads back to the master.
- Used as an on-chip/loopback target for bring-up and bench verification of the camera configuration path; also exposes write strobes to fabric.

Parameters:
- DEVICE_ADDR, 7'h21, 7-bit address this target answers to.
- NUM_REGS, 16, register file depth in bytes; must be a power of 2, at most 256.
- FILTER_LEN, 3, number of consecutive identical clk samples required before a filtered SCL/SDA level changes.

Ports:
- clk  in  1  system clock, at least 20x SCL.
- rst_n  in  1  async active-low reset.
- scl  in  1  I2C clock from master; no clock stretching.
- sda  inout  1  open-drain data; driven 1'b0 or 1'bz only, never 1.
- wr_strobe  out  1  one-clk pulse per register written by the bus.
- wr_addr  out  8  register index of the last bus write.
- wr_data  out  8  data of the last bus write.
- rd_idx  in  $clog2(NUM_REGS)  fabric-side peek index.
- rd_val  out  8  combinational regfile[rd_idx].
- busy  out  1  high from START to STOP.

Behaviour:
- Reset: asynchronous on rst_n low; clock is clk.
  - Reset values: sda released (z), wr_strobe=0, wr_addr=0, wr_data=0, busy=0, state=IDLE, pointer=0, all registers 8'h00.
- Input conditioning:
  - 2-flop synchroniser on scl and sda, then the FILTER_LEN glitch filter.
  - Edge detect on the filtered signals gives scl_rise, scl_fall, sda_fall, sda_rise.
- Conditions:
  - START = sda_fall while filtered scl=1.
  - STOP = sda_rise while filtered scl=1.
  - Both are valid in any state and take priority over bit handling. Repeated START is allowed.
- Bit timing:
  - SDA is sampled on scl_rise, MSB first.
  - The target changes its sda drive on the clk after scl_fall.
- Bit counter: 3 bits; the 8th bit completes a byte.
- State machine:
  - IDLE: START -> DEV_ADDR, busy=1.
  - DEV_ADDR: shift 8 bits.
    - addr==DEVICE_ADDR -> ADDR_ACK.
    - Otherwise -> IGNORE, with sda released until the next START/STOP.
  - ADDR_ACK: drive 0 for one SCL period, falling edge to falling edge.
    - Then R/W=0 -> REG_PTR.
    - R/W=1 -> RD_DATA, with the shift register loaded from regfile[pointer].
  - REG_PTR: receive 8 bits, pointer <= byte mod NUM_REGS, ACK -> WR_DATA.
  - WR_DATA: receive 8 bits, then ACK.
    - Write regfile[pointer] on the 8th scl_rise.
    - wr_strobe pulses on that same cycle; wr_addr/wr_data are updated on that same cycle.
    - pointer increments and wraps NUM_REGS-1 -> 0.
    - Stays in WR_DATA for subsequent bytes.
  - RD_DATA: drive the shift MSB after each scl_fall (0 -> drive low, 1 -> release). After 8 bits, release -> RD_ACK.
  - RD_ACK: sample master ACK on scl_rise.
    - ACK (0): pointer++ (wraps), reload shift register, -> RD_DATA.
    - NACK (1): -> IGNORE, bus released.
- STOP in any state: -> IDLE, busy=0, sda released.
- Pointer persistence: pointer persists across transactions, so a write of only the pointer followed by a read transaction reads from that pointer.
- Simultaneous events: START/STOP aborts any byte in progress. A partial WR_DATA byte is not written and gives no strobe.
- Address boundary: a pointer byte >= NUM_REGS is reduced modulo NUM_REGS.
- Reset mid-transaction: sda is released immediately (async); the master sees a NACK or arbitration loss.
- General call (addr 0) is not supported and gets a NACK.

Decomposition:
- Shared package i2c_pkg:
  - I2C condition/state enum typedef (target_state_t: IDLE, DEV_ADDR, ADDR_ACK, REG_PTR, WR_DATA, RD_DATA, RD_ACK, IGNORE).
  - Bus constants: ACK=1'b0, NACK=1'b1, RW_WRITE=1'b0, RW_READ=1'b1.
  - The command-register opcodes shared with the master controller (8'h90, 8'h10, 8'h50).
- Sub-module: i2c_line_filter, instantiated twice (scl, sda). Contains synchroniser, FILTER_LEN counter and rise/fall pulses.

Test Plan:
1. Master writes dev 0x21 W, ptr 0x03, data 0xA5 -> three ACKs; wr_strobe once with wr_addr=0x03, wr_data=0xA5; rd_idx=3 gives rd_val=0xA5; busy falls after STOP.
2. Write dev 0x21 W, ptr 0x0F, data 0x11, 0x22 -> regs[15]=0x11, regs[0]=0x22 (wrap); two strobes.
3. Write ptr 0x02, repeated START, dev 0x21 R, master ACK then NACK -> bytes regs[2], regs[3] returned; bus released after NACK; STOP -> IDLE.
4. Address 0x42 W followed by 3 bytes -> no ACK on any bit, no wr_strobe, sda never driven; a following START to 0x21 works normally.
5. Glitch: 1-clk SDA pulse low while SCL high (shorter than FILTER_LEN) -> no START detected, state stays IDLE, busy=0.
6. STOP after 4 bits of a data byte -> no register change, no strobe; rst_n asserted during RD_DATA -> sda=z the same cycle, all regs 0x00.
